// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: master count,
// FSM state encoding and the master-index type.
package wb_pkg;

    localparam int NM = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef logic [2:0] master_idx_t;

endpackage

// File: rtl/wb_rr_arb_if.sv
// Request/grant bundle between the bus masters and the round-robin arbiter.
interface wb_rr_arb_if;
    import wb_pkg::*;

    logic [NM-1:0] req;
    logic [NM-1:0] gnt;
    master_idx_t   gnt_id;
    logic          busy;
    logic          hold_to;

    modport master (output req, input gnt, gnt_id, busy, hold_to);
    modport slave  (input req, output gnt, gnt_id, busy, hold_to);

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational rotate-priority encoder: first set request after 'last', wrapping mod NM.
module wb_rr_pick
    import wb_pkg::*;
(
    input  logic [NM-1:0] req,
    input  master_idx_t   last,
    output logic          found,
    output master_idx_t   idx
);

    master_idx_t cand;

    // Scan from the farthest candidate back to the nearest so the nearest set bit wins.
    always_comb begin
        found = |req;
        idx   = '0;
        cand  = '0;
        for (int i = NM; i >= 1; i--) begin
            cand = master_idx_t'((int'(last) + i) % NM);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arb.sv
// Round-robin Wishbone arbiter: registered one-hot grant held for the owner's
// whole cycle, with a one-shot flag for contended tenures that run too long.
module wb_rr_arb
    import wb_pkg::*;
#(
    parameter int MAX_HOLD = 256,
    parameter int HW       = 9     // 2**HW must exceed MAX_HOLD
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    wb_rr_arb_if.slave  bus
);

    state_t        state, state_nxt;
    master_idx_t   last, last_nxt;
    master_idx_t   pick_idx;
    logic          pick_found;
    logic [HW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          flagged, flagged_nxt;
    logic [NM-1:0] gnt_nxt;
    master_idx_t   gnt_id_nxt;
    logic          busy_nxt, hold_to_nxt;
    logic          owner_req, contention;

    assign owner_req  = |(bus.req & bus.gnt);
    assign contention = |(bus.req & ~bus.gnt);

    wb_rr_pick u_pick (
        .req   (bus.req),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = GRANT;
            GRANT:   if (!owner_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // 'flagged' keeps the timeout to a single pulse per tenure once the counter saturates.
    always_comb begin
        gnt_nxt     = bus.gnt;
        gnt_id_nxt  = bus.gnt_id;
        busy_nxt    = bus.busy;
        hold_to_nxt = 1'b0;
        cnt_nxt     = cnt;
        cnt_inc     = (cnt == HW'(MAX_HOLD)) ? cnt : cnt + 1'b1;
        flagged_nxt = flagged;
        last_nxt    = last;
        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                flagged_nxt = 1'b0;
                if (pick_found) begin
                    gnt_nxt    = NM'(1) << pick_idx;
                    gnt_id_nxt = pick_idx;
                    busy_nxt   = 1'b1;
                end else begin
                    gnt_nxt    = '0;
                    gnt_id_nxt = '0;
                    busy_nxt   = 1'b0;
                end
            end
            GRANT: begin
                if (owner_req) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc >= HW'(MAX_HOLD - 1) && contention && !flagged) begin
                        hold_to_nxt = 1'b1;
                        flagged_nxt = 1'b1;
                    end
                end else begin
                    gnt_nxt     = '0;
                    gnt_id_nxt  = '0;
                    busy_nxt    = 1'b0;
                    last_nxt    = bus.gnt_id;
                    cnt_nxt     = '0;
                    flagged_nxt = 1'b0;
                end
            end
            default: begin
                gnt_nxt    = '0;
                gnt_id_nxt = '0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bus.gnt     <= '0;
            bus.gnt_id  <= '0;
            bus.busy    <= 1'b0;
            bus.hold_to <= 1'b0;
            cnt         <= '0;
            flagged     <= 1'b0;
            last        <= master_idx_t'(NM - 1);
        end else begin
            bus.gnt     <= gnt_nxt;
            bus.gnt_id  <= gnt_id_nxt;
            bus.busy    <= busy_nxt;
            bus.hold_to <= hold_to_nxt;
            cnt         <= cnt_nxt;
            flagged     <= flagged_nxt;
            last        <= last_nxt;
        end
    end

endmodule
